// File: rtl/reorder_buffer.sv
// In-order retirement buffer: rename allocates by tag, execution units mark entries done,
// and the oldest done entry retires one per cycle into the RRAT / free-list release path.
module reorder_buffer #(
    parameter int DEPTH  = 16,
    parameter int IDX_W  = 4,
    parameter int ARCH_W = 5,
    parameter int PHYS_W = 6
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              FLUSH,
    input  logic              alloc_valid,
    input  logic [ARCH_W-1:0] alloc_arch_reg,
    input  logic [PHYS_W-1:0] alloc_phys_reg,
    input  logic              alloc_reg_write,
    input  logic              alloc_is_store,
    input  logic [31:0]       alloc_pc,
    output logic              alloc_ready,
    output logic [IDX_W-1:0]  alloc_tag,
    input  logic              complete_valid,
    input  logic [IDX_W-1:0]  complete_tag,
    output logic              commit_valid,
    output logic [ARCH_W-1:0] commit_arch_reg,
    output logic [PHYS_W-1:0] commit_phys_reg,
    output logic              commit_reg_write,
    output logic              commit_is_store,
    output logic [31:0]       commit_pc,
    output logic [IDX_W:0]    count,
    output logic              empty
);

    localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(DEPTH);

    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [DEPTH-1:0]  done_q, done_d;
    logic [IDX_W-1:0]  head_q, head_d;
    logic [IDX_W-1:0]  tail_q, tail_d;
    logic [IDX_W:0]    count_q, count_d;

    logic [ARCH_W-1:0] arch_q [DEPTH];
    logic [ARCH_W-1:0] arch_d [DEPTH];
    logic [PHYS_W-1:0] phys_q [DEPTH];
    logic [PHYS_W-1:0] phys_d [DEPTH];
    logic [DEPTH-1:0]  regw_q, regw_d;
    logic [DEPTH-1:0]  store_q, store_d;
    logic [31:0]       pc_q [DEPTH];
    logic [31:0]       pc_d [DEPTH];

    logic              commit_valid_q, commit_valid_d;
    logic [ARCH_W-1:0] commit_arch_q, commit_arch_d;
    logic [PHYS_W-1:0] commit_phys_q, commit_phys_d;
    logic              commit_regw_q, commit_regw_d;
    logic              commit_store_q, commit_store_d;
    logic [31:0]       commit_pc_q, commit_pc_d;

    logic alloc_fire;
    logic retire;

    assign alloc_ready      = (count_q != FULL_CNT);
    assign alloc_tag        = tail_q;
    assign alloc_fire       = alloc_valid & alloc_ready;
    // Retire decision looks only at registered state, so a same-edge completion waits a cycle.
    assign retire           = valid_q[head_q] & done_q[head_q];

    assign commit_valid     = commit_valid_q;
    assign commit_arch_reg  = commit_arch_q;
    assign commit_phys_reg  = commit_phys_q;
    assign commit_reg_write = commit_regw_q;
    assign commit_is_store  = commit_store_q;
    assign commit_pc        = commit_pc_q;
    assign count            = count_q;
    assign empty            = (count_q == '0);

    always_comb begin
        valid_d        = valid_q;
        done_d         = done_q;
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        arch_d         = arch_q;
        phys_d         = phys_q;
        regw_d         = regw_q;
        store_d        = store_q;
        pc_d           = pc_q;
        commit_valid_d = 1'b0;
        commit_arch_d  = commit_arch_q;
        commit_phys_d  = commit_phys_q;
        commit_regw_d  = commit_regw_q;
        commit_store_d = commit_store_q;
        commit_pc_d    = commit_pc_q;

        if (FLUSH) begin
            valid_d = '0;
            done_d  = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (complete_valid && valid_q[complete_tag] && !done_q[complete_tag]) begin
                done_d[complete_tag] = 1'b1;
            end

            if (retire) begin
                commit_valid_d  = 1'b1;
                commit_arch_d   = arch_q[head_q];
                commit_phys_d   = phys_q[head_q];
                commit_regw_d   = regw_q[head_q];
                commit_store_d  = store_q[head_q];
                commit_pc_d     = pc_q[head_q];
                valid_d[head_q] = 1'b0;
                done_d[head_q]  = 1'b0;
                head_d          = head_q + 1'b1;
            end

            // tail never aliases head or a completing entry here: tail is free whenever alloc fires.
            if (alloc_fire) begin
                valid_d[tail_q] = 1'b1;
                done_d[tail_q]  = 1'b0;
                arch_d[tail_q]  = alloc_arch_reg;
                phys_d[tail_q]  = alloc_phys_reg;
                regw_d[tail_q]  = alloc_reg_write;
                store_d[tail_q] = alloc_is_store;
                pc_d[tail_q]    = alloc_pc;
                tail_d          = tail_q + 1'b1;
            end

            count_d = count_q + (IDX_W+1)'(alloc_fire) - (IDX_W+1)'(retire);
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            valid_q        <= '0;
            done_q         <= '0;
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            commit_valid_q <= 1'b0;
            commit_arch_q  <= '0;
            commit_phys_q  <= '0;
            commit_regw_q  <= 1'b0;
            commit_store_q <= 1'b0;
            commit_pc_q    <= '0;
        end else begin
            valid_q        <= valid_d;
            done_q         <= done_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            commit_valid_q <= commit_valid_d;
            commit_arch_q  <= commit_arch_d;
            commit_phys_q  <= commit_phys_d;
            commit_regw_q  <= commit_regw_d;
            commit_store_q <= commit_store_d;
            commit_pc_q    <= commit_pc_d;
        end
    end

    // Payload is qualified by valid bits, so it needs no reset.
    always_ff @(posedge CLK) begin
        arch_q  <= arch_d;
        phys_q  <= phys_d;
        regw_q  <= regw_d;
        store_q <= store_d;
        pc_q    <= pc_d;
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: queue-based reference model checked every cycle, plus directed
// scenarios with hand-computed expectations.
module tb_reorder_buffer;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        FLUSH;
    logic        alloc_valid;
    logic [4:0]  alloc_arch_reg;
    logic [5:0]  alloc_phys_reg;
    logic        alloc_reg_write;
    logic        alloc_is_store;
    logic [31:0] alloc_pc;
    logic        alloc_ready;
    logic [3:0]  alloc_tag;
    logic        complete_valid;
    logic [3:0]  complete_tag;
    logic        commit_valid;
    logic [4:0]  commit_arch_reg;
    logic [5:0]  commit_phys_reg;
    logic        commit_reg_write;
    logic        commit_is_store;
    logic [31:0] commit_pc;
    logic [4:0]  count;
    logic        empty;

    int vectors = 0;
    int miscompares = 0;

    reorder_buffer dut (
        .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH),
        .alloc_valid(alloc_valid), .alloc_arch_reg(alloc_arch_reg),
        .alloc_phys_reg(alloc_phys_reg), .alloc_reg_write(alloc_reg_write),
        .alloc_is_store(alloc_is_store), .alloc_pc(alloc_pc),
        .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .complete_valid(complete_valid), .complete_tag(complete_tag),
        .commit_valid(commit_valid), .commit_arch_reg(commit_arch_reg),
        .commit_phys_reg(commit_phys_reg), .commit_reg_write(commit_reg_write),
        .commit_is_store(commit_is_store), .commit_pc(commit_pc),
        .count(count), .empty(empty)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          tag;
        bit          done;
        logic [4:0]  arch;
        logic [5:0]  phys;
        logic        regw;
        logic        store;
        logic [31:0] pc;
    } ent_t;

    ent_t        mq[$];
    int          m_tail = 0;
    logic        m_cv = 0;
    logic [4:0]  m_arch = 0;
    logic [5:0]  m_phys = 0;
    logic        m_regw = 0;
    logic        m_store = 0;
    logic [31:0] m_pc = 0;

    task automatic model_clear();
        mq.delete();
        m_tail = 0;
        m_cv   = 0;
    endtask

    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            model_clear();
            m_arch = 0; m_phys = 0; m_regw = 0; m_store = 0; m_pc = 0;
        end else if (FLUSH) begin
            model_clear();
        end else begin
            bit   do_retire;
            bit   do_alloc;
            ent_t e;
            do_retire = (mq.size() > 0) && mq[0].done;
            do_alloc  = alloc_valid && (mq.size() < 16);
            if (complete_valid)
                foreach (mq[i]) if (mq[i].tag == int'(complete_tag)) mq[i].done = 1;
            if (do_retire) begin
                m_cv = 1;
                m_arch = mq[0].arch; m_phys = mq[0].phys;
                m_regw = mq[0].regw; m_store = mq[0].store; m_pc = mq[0].pc;
                void'(mq.pop_front());
            end else begin
                m_cv = 0;
            end
            if (do_alloc) begin
                e.tag = m_tail; e.done = 0;
                e.arch = alloc_arch_reg; e.phys = alloc_phys_reg;
                e.regw = alloc_reg_write; e.store = alloc_is_store; e.pc = alloc_pc;
                mq.push_back(e);
                m_tail = (m_tail + 1) % 16;
            end
        end
    end

    always @(negedge CLK) begin
        logic       exp_ready;
        logic [3:0] exp_tag;
        logic [4:0] exp_cnt;
        exp_ready = (mq.size() != 16);
        exp_tag   = 4'(m_tail);
        exp_cnt   = 5'(mq.size());
        vectors++;
        if (alloc_ready !== exp_ready || alloc_tag !== exp_tag || count !== exp_cnt ||
            empty !== (mq.size() == 0) || commit_valid !== m_cv ||
            commit_arch_reg !== m_arch || commit_phys_reg !== m_phys ||
            commit_reg_write !== m_regw || commit_is_store !== m_store || commit_pc !== m_pc) begin
            miscompares++;
            $display("FAIL model_cycle t=%0t got rdy=%b tag=%0d cnt=%0d emp=%b cv=%b arch=%0d phys=%0d rw=%b st=%b pc=%h exp rdy=%b tag=%0d cnt=%0d emp=%b cv=%b arch=%0d phys=%0d rw=%b st=%b pc=%h",
                     $time, alloc_ready, alloc_tag, count, empty, commit_valid, commit_arch_reg,
                     commit_phys_reg, commit_reg_write, commit_is_store, commit_pc,
                     exp_ready, exp_tag, exp_cnt, (mq.size() == 0), m_cv, m_arch, m_phys,
                     m_regw, m_store, m_pc);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s got %0h exp %0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        alloc_valid    = 1'b0;
        complete_valid = 1'b0;
        FLUSH          = 1'b0;
    endtask

    task automatic alloc(input logic [4:0] a, input logic [5:0] p, input logic [31:0] pc);
        alloc_valid     = 1'b1;
        alloc_arch_reg  = a;
        alloc_phys_reg  = p;
        alloc_reg_write = a[0];
        alloc_is_store  = p[0];
        alloc_pc        = pc;
    endtask

    task automatic complete(input logic [3:0] t);
        complete_valid = 1'b1;
        complete_tag   = t;
    endtask

    task automatic do_reset();
        RESET = 1'b0;
        tick();
        RESET = 1'b1;
    endtask

    initial begin
        RESET = 1'b0; FLUSH = 1'b0; alloc_valid = 1'b0; complete_valid = 1'b0;
        alloc_arch_reg = '0; alloc_phys_reg = '0; alloc_reg_write = 1'b0;
        alloc_is_store = 1'b0; alloc_pc = '0; complete_tag = '0;
        repeat (2) tick();
        RESET = 1'b1;
        chk("reset_ready", 32'(alloc_ready), 1);
        chk("reset_tag", 32'(alloc_tag), 0);
        chk("reset_empty", 32'(empty), 1);
        chk("reset_cv", 32'(commit_valid), 0);

        // 1: out-of-order completion, in-order retirement
        for (int i = 0; i < 3; i++) begin
            chk("t1_alloc_tag", 32'(alloc_tag), 32'(i));
            alloc(5'(i + 3), 6'(i + 40), 32'h1000 + 32'(4 * i));
            tick();
        end
        complete(4'd2); tick();
        complete(4'd1); tick();
        complete(4'd0); tick();
        chk("t1_no_early_commit", 32'(commit_valid), 0);
        tick();
        chk("t1_c0_valid", 32'(commit_valid), 1);
        chk("t1_c0_arch", 32'(commit_arch_reg), 3);
        chk("t1_c0_pc", commit_pc, 32'h1000);
        tick();
        chk("t1_c1_arch", 32'(commit_arch_reg), 4);
        tick();
        chk("t1_c2_arch", 32'(commit_arch_reg), 5);
        chk("t1_c2_phys", 32'(commit_phys_reg), 42);
        tick();
        chk("t1_idle_cv", 32'(commit_valid), 0);
        chk("t1_hold_arch", 32'(commit_arch_reg), 5);

        // 2: full, retire-cycle allocation rejected
        do_reset();
        for (int i = 0; i < 16; i++) begin
            alloc(5'(i), 6'(i + 16), 32'h2000 + 32'(4 * i));
            tick();
        end
        chk("t2_count_full", 32'(count), 16);
        chk("t2_ready_full", 32'(alloc_ready), 0);
        complete(4'd0); tick();
        chk("t2_ready_retire_cycle", 32'(alloc_ready), 0);
        alloc(5'd30, 6'd30, 32'h2fff);
        tick();
        chk("t2_retire_cv", 32'(commit_valid), 1);
        chk("t2_count_after", 32'(count), 15);
        chk("t2_ready_after", 32'(alloc_ready), 1);
        chk("t2_tag_after", 32'(alloc_tag), 0);
        alloc(5'd31, 6'd31, 32'h3000);
        tick();
        chk("t2_count_refill", 32'(count), 16);

        // 3: completion at edge N -> pulse in cycle N+1
        complete(4'd1); tick();
        chk("t3_cv_edge_n", 32'(commit_valid), 0);
        tick();
        chk("t3_cv_edge_n1", 32'(commit_valid), 1);
        chk("t3_arch", 32'(commit_arch_reg), 1);
        chk("t3_phys", 32'(commit_phys_reg), 17);
        tick();
        chk("t3_single_pulse", 32'(commit_valid), 0);

        // 4: flush squashes pending retire
        do_reset();
        for (int i = 0; i < 5; i++) begin
            alloc(5'(10 + i), 6'(i), 32'h4000 + 32'(4 * i));
            tick();
        end
        for (int t = 1; t <= 3; t++) begin
            complete(4'(t)); tick();
        end
        complete(4'd0); tick();
        FLUSH = 1'b1; tick();
        chk("t4_cv", 32'(commit_valid), 0);
        chk("t4_count", 32'(count), 0);
        chk("t4_empty", 32'(empty), 1);
        repeat (3) tick();
        chk("t4_cv_later", 32'(commit_valid), 0);
        chk("t4_tag", 32'(alloc_tag), 0);
        alloc(5'd9, 6'd9, 32'h4100); tick();

        // 5: completion to unallocated tag is ignored
        FLUSH = 1'b1; tick();
        complete(4'd7); tick();
        chk("t5_count", 32'(count), 0);
        chk("t5_empty", 32'(empty), 1);
        for (int i = 0; i < 8; i++) begin
            alloc(5'(i + 1), 6'(i + 50), 32'h5000 + 32'(4 * i));
            tick();
        end
        repeat (3) tick();
        chk("t5_count8", 32'(count), 8);
        chk("t5_no_commit", 32'(commit_valid), 0);
        complete(4'd7); tick();
        tick();
        chk("t5_tag7_blocked", 32'(commit_valid), 0);
        complete(4'd0); tick();
        tick();
        chk("t5_head_commit", 32'(commit_valid), 1);
        chk("t5_head_arch", 32'(commit_arch_reg), 1);

        // 6: async reset mid-operation
        FLUSH = 1'b1; tick();
        for (int i = 0; i < 4; i++) begin
            alloc(5'(20 + i), 6'(i + 33), 32'h6000 + 32'(4 * i));
            tick();
        end
        complete(4'd0); tick();
        tick();
        chk("t6_pre_cv", 32'(commit_valid), 1);
        #2;
        RESET = 1'b0;
        #1;
        chk("t6_cv_cleared", 32'(commit_valid), 0);
        chk("t6_arch_cleared", 32'(commit_arch_reg), 0);
        chk("t6_pc_cleared", commit_pc, 0);
        chk("t6_count_cleared", 32'(count), 0);
        tick();
        RESET = 1'b1;
        chk("t6_empty", 32'(empty), 1);
        chk("t6_tag", 32'(alloc_tag), 0);
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
